// File: rtl/grf.sv
// ----------------------------------------------------------------------------
// grf -- 32 x 32-bit general register file for the write-back / decode stages
//
// Register 0 is hard-wired to zero and is never written. Reads are
// combinational. Writes land on the rising clock edge. Alongside the storage,
// the block records a small write trace for debug:
//   - a wrapping count of effective writes
//   - the PC, register number and data of the most recent effective write
//
// Optional feature (macro GRF_BYPASS_EN):
//   When the macro is defined, a write in progress is forwarded straight to
//   any read port that addresses the same non-zero register. That read port
//   then returns RegWD in the same cycle.
//   When the macro is not defined, reads return only stored contents. During
//   a write cycle this is the pre-write value.
//
// Parameters:
//   CNT_W         width of the effective-write counter
//
// Ports:
//   clk           clock; all state updates on its rising edge
//   reset         asynchronous, active-high; clears storage and trace
//   W_Regwrite    write-back register-write enable
//   W_RegWreg     write-back destination register number
//   RegWD         write-back data
//   in_PC         PC of the instruction in write-back
//   D_rs_addr     decode rs read address
//   D_rt_addr     decode rt read address
//   D_rs_data     rs read data (combinational)
//   D_rt_data     rt read data (combinational)
//   wr_count      effective writes since reset, modulo 2^CNT_W
//   last_wr_pc    PC of the most recent effective write
//   last_wr_reg   register number of the most recent effective write
//   last_wr_data  data of the most recent effective write
// ----------------------------------------------------------------------------
module grf #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             W_Regwrite,
    input  logic [4:0]       W_RegWreg,
    input  logic [31:0]      RegWD,
    input  logic [31:0]      in_PC,
    input  logic [4:0]       D_rs_addr,
    input  logic [4:0]       D_rt_addr,
    output logic [31:0]      D_rs_data,
    output logic [31:0]      D_rt_data,
    output logic [CNT_W-1:0] wr_count,
    output logic [31:0]      last_wr_pc,
    output logic [4:0]       last_wr_reg,
    output logic [31:0]      last_wr_data
);

    logic [31:0]      regs_q [0:31];
    logic [31:0]      regs_d [0:31];
    logic [CNT_W-1:0] cnt_q,       cnt_d;
    logic [31:0]      lpc_q,       lpc_d;
    logic [4:0]       lreg_q,      lreg_d;
    logic [31:0]      ldata_q,     ldata_d;

    logic             wr_eff;

    // A write to $0 counts as "no write" everywhere: no storage change, no
    // trace update, and no forwarding.
    assign wr_eff = W_Regwrite && (W_RegWreg != 5'd0);

    // Next-state computation for storage and the write trace.
    always_comb begin
        regs_d  = regs_q;
        cnt_d   = cnt_q;
        lpc_d   = lpc_q;
        lreg_d  = lreg_q;
        ldata_d = ldata_q;
        if (wr_eff) begin
            regs_d[W_RegWreg] = RegWD;
            cnt_d             = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
            lpc_d             = in_PC;
            lreg_d            = W_RegWreg;
            ldata_d           = RegWD;
        end
    end

    // All state clears asynchronously. This discards any write whose edge
    // coincides with reset. Entry 0 is never written, so it stays 0 after
    // reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) begin
                regs_q[i] <= 32'd0;
            end
            cnt_q   <= '0;
            lpc_q   <= 32'd0;
            lreg_q  <= 5'd0;
            ldata_q <= 32'd0;
        end else begin
            regs_q  <= regs_d;
            cnt_q   <= cnt_d;
            lpc_q   <= lpc_d;
            lreg_q  <= lreg_d;
            ldata_q <= ldata_d;
        end
    end

    // Read ports.
    // Storage is already zero while reset is high. Forwarding is gated by
    // reset, so both ports read 0 for every address during reset.
    always_comb begin
        D_rs_data = (D_rs_addr == 5'd0) ? 32'd0 : regs_q[D_rs_addr];
        D_rt_data = (D_rt_addr == 5'd0) ? 32'd0 : regs_q[D_rt_addr];
`ifdef GRF_BYPASS_EN
        if (wr_eff && !reset && (D_rs_addr == W_RegWreg)) begin
            D_rs_data = RegWD;
        end
        if (wr_eff && !reset && (D_rt_addr == W_RegWreg)) begin
            D_rt_data = RegWD;
        end
`endif
    end

    assign wr_count     = cnt_q;
    assign last_wr_pc   = lpc_q;
    assign last_wr_reg  = lreg_q;
    assign last_wr_data = ldata_q;

endmodule

// File: tb/tb_grf.sv
// ----------------------------------------------------------------------------
// tb_grf -- self-checking bench for grf
//
// The DUT is built with a 4-bit counter so that counter wrap can be reached
// quickly. A behavioural model holds the expected register file contents and
// the expected write trace:
//   - mdl_regs: an array of 32 words
//   - mdl_cnt:  an integer, kept modulo 16
//
// Inputs change on the falling clock edge. Read ports are checked 1 ns later,
// before the rising edge. Registered outputs are checked 1 ns after the
// rising edge.
// ----------------------------------------------------------------------------
module tb_grf;

    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             reset;
    logic             W_Regwrite;
    logic [4:0]       W_RegWreg;
    logic [31:0]      RegWD;
    logic [31:0]      in_PC;
    logic [4:0]       D_rs_addr;
    logic [4:0]       D_rt_addr;
    logic [31:0]      D_rs_data;
    logic [31:0]      D_rt_data;
    logic [CNT_W-1:0] wr_count;
    logic [31:0]      last_wr_pc;
    logic [4:0]       last_wr_reg;
    logic [31:0]      last_wr_data;

    grf #(.CNT_W(CNT_W)) dut (
        .clk          (clk),
        .reset        (reset),
        .W_Regwrite   (W_Regwrite),
        .W_RegWreg    (W_RegWreg),
        .RegWD        (RegWD),
        .in_PC        (in_PC),
        .D_rs_addr    (D_rs_addr),
        .D_rt_addr    (D_rt_addr),
        .D_rs_data    (D_rs_data),
        .D_rt_data    (D_rt_data),
        .wr_count     (wr_count),
        .last_wr_pc   (last_wr_pc),
        .last_wr_reg  (last_wr_reg),
        .last_wr_data (last_wr_data)
    );

    always #5 clk = ~clk;

    // Reference model state.
    logic [31:0] mdl_regs [0:31];
    int          mdl_cnt;
    logic [31:0] mdl_pc;
    logic [31:0] mdl_reg;
    logic [31:0] mdl_data;

    int vectors = 0;
    int miscompares = 0;

    // Reset clears everything in the model.
    task automatic mdl_reset();
        for (int i = 0; i < 32; i++) begin
            mdl_regs[i] = 32'd0;
        end
        mdl_cnt  = 0;
        mdl_pc   = 32'd0;
        mdl_reg  = 32'd0;
        mdl_data = 32'd0;
    endtask

    // Expected read value, given the current inputs.
    function automatic logic [31:0] exp_read(input logic [4:0] a);
        if (reset || a == 5'd0) begin
            return 32'd0;
        end
`ifdef GRF_BYPASS_EN
        if (W_Regwrite && W_RegWreg != 5'd0 && W_RegWreg == a) begin
            return RegWD;
        end
`endif
        return mdl_regs[a];
    endfunction

    // Every comparison goes through here.
    task automatic checkOutput(input string tag,
                               input logic [31:0] obs,
                               input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Compare the registered write-trace outputs against the model.
    task automatic check_trace(input string tag);
        checkOutput({tag, ".wr_count"},     32'(wr_count),    32'(mdl_cnt));
        checkOutput({tag, ".last_wr_pc"},   last_wr_pc,       mdl_pc);
        checkOutput({tag, ".last_wr_reg"},  32'(last_wr_reg), mdl_reg);
        checkOutput({tag, ".last_wr_data"}, last_wr_data,     mdl_data);
    endtask

    // One clock cycle:
    //   1. Drive the inputs at the falling edge.
    //   2. Check both read ports.
    //   3. Apply the write to the model at the rising edge.
    //   4. Check the registered outputs.
    task automatic applyStimulus(input string tag,
                                 input logic we,
                                 input logic [4:0] wreg,
                                 input logic [31:0] wd,
                                 input logic [31:0] pc,
                                 input logic [4:0] ra,
                                 input logic [4:0] rb);
        @(negedge clk);
        W_Regwrite = we;
        W_RegWreg  = wreg;
        RegWD      = wd;
        in_PC      = pc;
        D_rs_addr  = ra;
        D_rt_addr  = rb;
        #1;
        checkOutput({tag, ".rs"}, D_rs_data, exp_read(ra));
        checkOutput({tag, ".rt"}, D_rt_data, exp_read(rb));
        @(posedge clk);
        if (reset) begin
            mdl_reset();
        end else if (we && wreg != 5'd0) begin
            mdl_regs[wreg] = wd;
            mdl_cnt        = (mdl_cnt + 1) % (1 << CNT_W);
            mdl_pc         = pc;
            mdl_reg        = 32'(wreg);
            mdl_data       = wd;
        end
        #1;
        check_trace(tag);
    endtask

    initial begin
        logic [31:0] r;

        // ---- power-on reset ----
        reset      = 1'b1;
        W_Regwrite = 1'b0;
        W_RegWreg  = 5'd0;
        RegWD      = 32'd0;
        in_PC      = 32'd0;
        D_rs_addr  = 5'd3;
        D_rt_addr  = 5'd17;
        mdl_reset();
        repeat (2) @(negedge clk);
        #1;
        checkOutput("por.rs", D_rs_data, 32'd0);
        checkOutput("por.rt", D_rt_data, 32'd0);
        check_trace("por");
        @(negedge clk);
        reset = 1'b0;

        // ---- write reg 8 with data 0xDEADBEEF, then read it back ----
        applyStimulus("w8", 1'b1, 5'd8, 32'hDEADBEEF, 32'h0000_3000, 5'd8, 5'd0);
        applyStimulus("r8", 1'b0, 5'd0, 32'd0, 32'd0, 5'd8, 5'd8);
        checkOutput("r8.direct_cnt", 32'(wr_count), 32'd1);
        checkOutput("r8.direct_pc",  last_wr_pc,    32'h0000_3000);

        // ---- a write to $0 must change nothing ----
        applyStimulus("w0", 1'b1, 5'd0, 32'h12345678, 32'h0000_3004, 5'd8, 5'd0);
        applyStimulus("r0", 1'b0, 5'd0, 32'd0, 32'd0, 5'd0, 5'd0);
        checkOutput("r0.direct_reg", 32'(last_wr_reg), 32'd8);

        // ---- same-cycle read while writing (bypass behaviour) ----
        applyStimulus("w9a",  1'b1, 5'd9, 32'h0000_0001, 32'h0000_3008, 5'd9, 5'd8);
        applyStimulus("w9b",  1'b1, 5'd9, 32'h55AA55AA,  32'h0000_300C, 5'd9, 5'd9);
        applyStimulus("r9",   1'b0, 5'd0, 32'd0,         32'd0,         5'd9, 5'd9);

        // ---- randomized traffic ----
        for (int i = 0; i < 80; i++) begin
            r = $urandom;
            applyStimulus("rnd", r[0] | r[1], 5'(r[6:2]), $urandom, $urandom,
                          5'(r[11:7]), (r[12] ? 5'(r[6:2]) : 5'(r[17:13])));
        end

        // ---- counter wrap after a fresh reset ----
        @(negedge clk);
        reset = 1'b1;
        mdl_reset();
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 16; i++) begin
            applyStimulus("wrap", 1'b1, 5'(1 + (i % 31)), $urandom, 32'(i * 4),
                          5'(1 + (i % 31)), 5'd1);
        end
        checkOutput("wrap.sixteen", 32'(wr_count), 32'd0);
        applyStimulus("wrap17", 1'b1, 5'd20, 32'hA5A5_0017, 32'h0000_4000, 5'd20, 5'd20);
        checkOutput("wrap.seventeen", 32'(wr_count), 32'd1);

        // ---- asynchronous reset asserted mid-cycle with preloaded regs ----
        applyStimulus("pre", 1'b1, 5'd12, 32'hCAFE_F00D, 32'h0000_5000, 5'd12, 5'd20);
        @(negedge clk);
        W_Regwrite = 1'b0;
        D_rs_addr  = 5'd12;
        D_rt_addr  = 5'd20;
        #2;
        reset = 1'b1;
        mdl_reset();
        #1;
        checkOutput("arst.rs", D_rs_data, 32'd0);
        checkOutput("arst.rt", D_rt_data, 32'd0);
        check_trace("arst");
        @(negedge clk);
        reset = 1'b0;

        // ---- reset coincident with a write to reg 5 ----
        applyStimulus("w5pre", 1'b1, 5'd5, 32'h0000_0055, 32'h0000_6000, 5'd5, 5'd5);
        @(negedge clk);
        W_Regwrite = 1'b1;
        W_RegWreg  = 5'd5;
        RegWD      = 32'h7777_7777;
        in_PC      = 32'h0000_6004;
        D_rs_addr  = 5'd5;
        D_rt_addr  = 5'd5;
        reset      = 1'b1;
        mdl_reset();
        #1;
        checkOutput("rstw.rs_during", D_rs_data, 32'd0);
        @(posedge clk);
        @(negedge clk);
        reset      = 1'b0;
        W_Regwrite = 1'b0;
        #1;
        checkOutput("rstw.rs_after", D_rs_data, 32'd0);
        checkOutput("rstw.cnt",      32'(wr_count), 32'd0);
        applyStimulus("postrst", 1'b1, 5'd5, 32'h0000_0123, 32'h0000_7000, 5'd5, 5'd0);
        applyStimulus("postrd",  1'b0, 5'd0, 32'd0, 32'd0, 5'd5, 5'd5);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    // Guard against a hung simulation.
    initial begin
        #200000;
        $display("[TB] FAIL timeout observed=running expected=finished");
        $fatal(1, "[TB] timeout");
    end

endmodule

// File: doc/grf.md
GRF -- requirements
Module: grf

Interface
REQ-001 Parameter: CNT_W, default 16, width of the effective-write counter.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 W_Regwrite  input  1  write-back stage register-write enable.
REQ-005 W_RegWreg  input  5  write-back destination register number.
REQ-006 RegWD  input  32  write-back data (ALU / DM / shift / PC+8, already selected).
REQ-007 in_PC  input  32  PC of the instruction in write-back.
REQ-008 D_rs_addr  input  5  decode-stage rs read address.
REQ-009 D_rt_addr  input  5  decode-stage rt read address.
REQ-010 D_rs_data  output  32  rs read data.
REQ-011 D_rt_data  output  32  rt read data.
REQ-012 wr_count  output  CNT_W  number of effective writes since reset.
REQ-013 last_wr_pc  output  32  PC of the most recent effective write.
REQ-014 last_wr_reg  output  5  register number of the most recent effective write.
REQ-015 last_wr_data  output  32  data of the most recent effective write.

Function
REQ-016 Storage SHALL be 32 registers of 32 bits; register 0 SHALL always read 0 and SHALL never be written.
REQ-017 An effective write SHALL be W_Regwrite=1 AND W_RegWreg!=0 at a rising clk edge with reset=0.
REQ-018 On an effective write, reg[W_RegWreg] SHALL take RegWD at that edge; the new value SHALL be visible on reads the following cycle.
REQ-019 Reads SHALL be combinational, with zero latency from D_rs_addr/D_rt_addr to D_rs_data/D_rt_data.
REQ-020 Both read ports SHALL be independent; equal addresses on both ports SHALL return identical data.
REQ-021 On an effective write, wr_count SHALL increment by 1, modulo 2^CNT_W (all-ones wraps to 0).
REQ-022 On an effective write, last_wr_pc/last_wr_reg/last_wr_data SHALL register in_PC/W_RegWreg/RegWD.
REQ-023 Writes with W_Regwrite=1 and W_RegWreg=0 SHALL change no state: no storage change, no count, no last_wr_* update.
REQ-024 With W_Regwrite=0, all state SHALL hold.
REQ-025 All outputs other than D_rs_data/D_rt_data SHALL be registered.

Reset
REQ-026 Asserting reset SHALL immediately, without waiting for clk, clear all 32 registers, wr_count, last_wr_pc, last_wr_reg and last_wr_data to 0.
REQ-027 A write whose edge coincides with reset=1 SHALL be discarded.
REQ-028 While reset=1, read ports SHALL return 0 for every address (bypass inactive).
REQ-029 The first effective write SHALL be taken at the first rising edge after reset deasserts.

Configuration
REQ-030 Macro GRF_BYPASS_EN SHALL control internal write-to-read forwarding.
REQ-031 With GRF_BYPASS_EN defined: when W_Regwrite=1, W_RegWreg!=0, reset=0 and the read address equals W_RegWreg, that read port SHALL return RegWD in the same cycle. Both ports SHALL be forwarded independently.
REQ-032 Without GRF_BYPASS_EN: read ports SHALL return stored contents only, i.e. the pre-write value during the write cycle.
REQ-033 Address 0 SHALL never be forwarded in either configuration.

Verification
REQ-034 Reset: assert reset mid-cycle with regs preloaded -> all D_*_data, wr_count and last_wr_* = 0 before the next clk edge.
REQ-035 Write/read: write reg 8 = 0xDEADBEEF with in_PC=0x00003000 -> next cycle D_rs_data(rs=8)=0xDEADBEEF; wr_count=1; last_wr_pc=0x00003000; last_wr_reg=8.
REQ-036 $0 write: W_Regwrite=1, W_RegWreg=0, RegWD=0x12345678 -> D_rt_data(rt=0)=0; wr_count and last_wr_* unchanged.
REQ-037 Same-cycle read of register 9 while writing 0x55AA55AA to it (old value 0x1) -> returns 0x55AA55AA with GRF_BYPASS_EN defined, 0x00000001 without it; 0x55AA55AA next cycle in both configurations.
REQ-038 Counter wrap: CNT_W=4, 16 effective writes -> wr_count=0; 17th write -> wr_count=1.
REQ-039 Reset coincident with write to reg 5 -> reg 5 reads 0 after reset deasserts; wr_count=0.
